// File: rtl/jtag_tap_multi_dr.sv
// jtag_tap_multi_dr: 1149.1 TAP with BYPASS, IDCODE and NUM_DR user data-register channels
module jtag_tap_multi_dr #(
  parameter int          IR_W       = 4,
  parameter int          NUM_DR     = 2,
  parameter int          DR_W       = 32,
  parameter logic [31:0] IDCODE_VAL = 32'h149511C3
) (
  input  logic                   tck_pad_i,
  input  logic                   trst_pad_i,
  input  logic                   tms_pad_i,
  input  logic                   tdi_pad_i,
  output logic                   tdo_pad_o,
  output logic                   tdo_padoe_o,
  output logic [3:0]             tap_state_o,
  output logic [IR_W-1:0]        ir_o,
  output logic [NUM_DR-1:0]      dr_sel_o,
  input  logic [NUM_DR*DR_W-1:0] dr_capture_i,
  output logic [NUM_DR*DR_W-1:0] dr_update_o,
  output logic [NUM_DR-1:0]      dr_update_stb_o
);
  typedef enum logic [3:0] {
    EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PA_DR  = 4'h3,
    SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
    EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PA_IR  = 4'hB,
    RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
  } state_t;
  localparam int CW = DR_W > 32 ? DR_W : 32;
  localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(1);
  state_t                   state_q, state_d;
  logic [IR_W-1:0]          ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [CW-1:0]            dr_sr_q, dr_sr_d, cap, shifted;
  logic [NUM_DR*DR_W-1:0]   upd_q, upd_d;
  logic [NUM_DR-1:0]        stb_q, stb_d;
  logic                     is_id;
  int                       len;
  always_ff @(posedge tck_pad_i)
    if (trst_pad_i) state_q <= TLR;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = tms_pad_i ? TLR    : RTI;
      RTI:     state_d = tms_pad_i ? SEL_DR : RTI;
      SEL_DR:  state_d = tms_pad_i ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = tms_pad_i ? EX1_DR : SH_DR;
      SH_DR:   state_d = tms_pad_i ? EX1_DR : SH_DR;
      EX1_DR:  state_d = tms_pad_i ? UPD_DR : PA_DR;
      PA_DR:   state_d = tms_pad_i ? EX2_DR : PA_DR;
      EX2_DR:  state_d = tms_pad_i ? UPD_DR : SH_DR;
      UPD_DR:  state_d = tms_pad_i ? SEL_DR : RTI;
      SEL_IR:  state_d = tms_pad_i ? TLR    : CAP_IR;
      CAP_IR:  state_d = tms_pad_i ? EX1_IR : SH_IR;
      SH_IR:   state_d = tms_pad_i ? EX1_IR : SH_IR;
      EX1_IR:  state_d = tms_pad_i ? UPD_IR : PA_IR;
      PA_IR:   state_d = tms_pad_i ? EX2_IR : PA_IR;
      EX2_IR:  state_d = tms_pad_i ? UPD_IR : SH_IR;
      UPD_IR:  state_d = tms_pad_i ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end
  always_comb begin
    is_id = ir_q == IR_IDCODE;
    for (int k = 0; k < NUM_DR; k++) dr_sel_o[k] = ir_q == IR_W'(k + 2);
    len = is_id ? 32 : (|dr_sel_o) ? DR_W : 1;
    tdo_padoe_o = state_q == SH_DR || state_q == SH_IR;
    tdo_pad_o = state_q == SH_IR ? ir_sr_q[0] : state_q == SH_DR ? dr_sr_q[0] : 1'b0;
  end
  // The DR shifter is shared; TDI is inserted at the MSB of whichever chain is active.
  always_comb begin
    cap = is_id ? CW'(IDCODE_VAL) : '0;
    for (int k = 0; k < NUM_DR; k++)
      if (dr_sel_o[k]) cap = CW'(dr_capture_i[k*DR_W +: DR_W]);
    shifted = {1'b0, dr_sr_q[CW-1:1]};
    for (int i = 0; i < CW; i++)
      if (i == len - 1) shifted[i] = tdi_pad_i;
    dr_sr_d = state_q == CAP_DR ? cap : state_q == SH_DR ? shifted : dr_sr_q;
    ir_sr_d = state_q == CAP_IR ? IR_W'(1) : state_q == SH_IR ? {tdi_pad_i, ir_sr_q[IR_W-1:1]} : ir_sr_q;
    ir_d = state_d == TLR ? IR_IDCODE : state_q == UPD_IR ? ir_sr_q : ir_q;
    upd_d = upd_q;
    for (int k = 0; k < NUM_DR; k++)
      if (state_q == UPD_DR && dr_sel_o[k]) upd_d[k*DR_W +: DR_W] = dr_sr_q[DR_W-1:0];
    stb_d = state_q == UPD_DR ? dr_sel_o : '0;
  end
  always_ff @(posedge tck_pad_i)
    if (trst_pad_i) begin
      ir_q    <= IR_IDCODE;
      ir_sr_q <= '0;
      dr_sr_q <= '0;
      upd_q   <= '0;
      stb_q   <= '0;
    end else begin
      ir_q    <= ir_d;
      ir_sr_q <= ir_sr_d;
      dr_sr_q <= dr_sr_d;
      upd_q   <= upd_d;
      stb_q   <= stb_d;
    end
  assign tap_state_o     = state_q;
  assign ir_o            = ir_q;
  assign dr_update_o     = upd_q;
  assign dr_update_stb_o = stb_q;
endmodule

// File: tb/tb_jtag_tap_multi_dr.sv
// tb_jtag_tap_multi_dr: random scans against a bit-stream model of the TAP chains
module tb_jtag_tap_multi_dr;
  logic        tck = 0;
  logic        trst, tms, tdi;
  logic        tdo, oe;
  logic [3:0]  state;
  logic [3:0]  ir;
  logic [1:0]  sel, stb;
  logic [63:0] dr_cap, upd;
  int n_vec = 0, n_err = 0;
  logic so, soe;
  logic [3:0]  ir_m;
  logic [63:0] upd_m;
  logic [3:0] nt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                           4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
  logic [3:0] nt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                           4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
  logic [3:0] codes [9] = '{4'h1, 4'h2, 4'h3, 4'h7, 4'hF, 4'h0, 4'h4, 4'h2, 4'h3};

  jtag_tap_multi_dr dut (
    .tck_pad_i(tck), .trst_pad_i(trst), .tms_pad_i(tms), .tdi_pad_i(tdi),
    .tdo_pad_o(tdo), .tdo_padoe_o(oe), .tap_state_o(state), .ir_o(ir),
    .dr_sel_o(sel), .dr_capture_i(dr_cap), .dr_update_o(upd), .dr_update_stb_o(stb)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic t, input logic d);
    tms = t;
    tdi = d;
    #1;
    so  = tdo;
    soe = oe;
    @(posedge tck);
    #1;
  endtask

  task automatic do_reset();
    trst = 1;
    step(0, 0);
    trst = 0;
    ir_m  = 4'h1;
    upd_m = '0;
    chk("rst_state", state, 4'hF);
    chk("rst_ir", ir, 4'h1);
    chk("rst_sel", sel, 2'b00);
    chk("rst_upd", upd, upd_m);
    chk("rst_stb", stb, 2'b00);
    chk("rst_tdo", {tdo, oe}, 2'b00);
    step(0, 0);
  endtask

  task automatic scan(input bit is_ir, input logic [63:0] din, input int n, input bit pause,
                      output logic [63:0] dout, output bit oe_ok);
    dout  = '0;
    oe_ok = 1;
    step(1, 0);
    if (is_ir) step(1, 0);
    step(0, 0);
    step(0, 0);
    oe_ok &= !soe;
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i]);
      dout[i] = so;
      oe_ok &= soe;
    end
    if (pause) begin
      step(0, 0);
      repeat (2) begin
        step(0, 1);
        oe_ok &= !soe;
      end
      step(1, 0);
      step(1, 0);
    end else step(1, 0);
    step(0, 0);
    oe_ok &= !soe;
  endtask

  function automatic logic [1:0] sel_of(input logic [3:0] c);
    return c == 4'h2 ? 2'b01 : c == 4'h3 ? 2'b10 : 2'b00;
  endfunction

  task automatic ir_op(input logic [63:0] din, input int n, input bit pause);
    logic [127:0] combo, mn;
    logic [63:0] dout;
    bit ok;
    mn = (128'd1 << n) - 1;
    combo = ((128'(din) & mn) << 4) | 128'd1;
    scan(1, din, n, pause, dout, ok);
    ir_m = 4'((combo >> n) & 128'hF);
    chk("ir_tdo", 128'(dout) & mn, combo & mn);
    chk("ir_oe", ok, 1);
    chk("ir_state", state, 4'hC);
    chk("ir_val", ir, ir_m);
    chk("ir_sel", sel, sel_of(ir_m));
  endtask

  task automatic dr_op(input logic [63:0] din, input int n, input bit pause);
    logic [127:0] combo, mn, cap, ch;
    logic [63:0] dout;
    logic [1:0] stb_e;
    int len;
    bit ok;
    len = (ir_m == 4'h1 || sel_of(ir_m) != 0) ? 32 : 1;
    cap = ir_m == 4'h1 ? 128'h149511C3 : ir_m == 4'h2 ? 128'(dr_cap[31:0]) :
          ir_m == 4'h3 ? 128'(dr_cap[63:32]) : 128'd0;
    mn = (128'd1 << n) - 1;
    combo = ((128'(din) & mn) << len) | cap;
    ch = (combo >> n) & ((128'd1 << len) - 1);
    scan(0, din, n, pause, dout, ok);
    stb_e = sel_of(ir_m);
    if (ir_m == 4'h2) upd_m[31:0] = ch[31:0];
    if (ir_m == 4'h3) upd_m[63:32] = ch[31:0];
    chk("dr_tdo", 128'(dout) & mn, combo & mn);
    chk("dr_oe", ok, 1);
    chk("dr_state", state, 4'hC);
    chk("dr_sel", sel, sel_of(ir_m));
    chk("dr_upd", upd, upd_m);
    chk("dr_stb", stb, stb_e);
    step(0, 0);
    chk("dr_stb_clr", stb, 2'b00);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] s_m;
    trst = 1; tms = 1; tdi = 0; dr_cap = '0;
    @(posedge tck);
    #1;
    do_reset();
    dr_op(64'd0, 32, 0);
    ir_op(64'hF, 4, 0);
    dr_op(64'hA5, 8, 0);
    ir_op(64'h2, 4, 0);
    dr_op(64'hDEADBEEF, 32, 0);
    chk("user0_write", upd[31:0], 32'hDEADBEEF);
    chk("user1_keep", upd[63:32], 32'h0);
    dr_cap = {32'h12345678, 32'h0};
    ir_op(64'h3, 4, 0);
    dr_op(64'd0, 32, 1);
    ir_op(64'h7, 4, 0);
    dr_op(64'h5A, 9, 0);
    repeat (60) begin
      dr_cap = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 3) == 0) ir_op({$urandom, $urandom}, $urandom_range(1, 8), $urandom_range(0, 1) == 1);
        else ir_op(64'(codes[$urandom_range(0, 8)]), 4, $urandom_range(0, 1) == 1);
      end else dr_op({$urandom, $urandom}, $urandom_range(1, 48), $urandom_range(0, 1) == 1);
    end
    ir_op(64'h2, 4, 0);
    dr_op({$urandom, $urandom}, 32, 0);
    ir_op(64'h2, 4, 0);
    step(1, 0); step(0, 0); step(0, 0);
    repeat (10) step(0, 1'($urandom));
    trst = 1;
    step(0, 0);
    trst = 0;
    chk("mid_rst_state", state, 4'hF);
    chk("mid_rst_ir", ir, 4'h1);
    chk("mid_rst_stb", stb, 2'b00);
    chk("mid_rst_upd", upd, 64'd0);
    ir_m = 4'h1;
    upd_m = '0;
    step(0, 0);
    ir_op(64'h3, 4, 0);
    dr_op({$urandom, $urandom}, 32, 0);
    ir_op(64'hF, 4, 0);
    step(1, 0); step(0, 0); step(0, 0);
    repeat (5) step(1, 0);
    chk("tms_rst_state", state, 4'hF);
    chk("tms_rst_ir", ir, 4'h1);
    chk("tms_rst_upd", upd, upd_m);
    ir_m = 4'h1;
    step(0, 0);
    s_m = 4'hC;
    for (int i = 1; i <= 300; i++) begin
      if (i % 40 == 0) begin
        repeat (5) step(1, 1'($urandom));
        s_m = 4'hF;
        chk("walk_tlr", state, s_m);
      end else begin
        tms = 1'($urandom);
        step(tms, 1'($urandom));
        s_m = tms ? nt1[s_m] : nt0[s_m];
        chk("walk_state", state, s_m);
        chk("walk_stb_onehot", $countones(stb) <= 1, 1);
      end
    end
    do_reset();
    dr_op(64'd0, 32, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/jtag_tap_multi_dr.md
# jtag_tap_multi_dr

Parametrised IEEE 1149.1-style TAP controller that generalises the team's fixed-width tap_top. It provides a configurable IR length and NUM_DR user data-register channels, each DR_W bits wide, alongside the mandatory BYPASS and IDCODE registers. It sits between the JTAG pads and the configuration logic (scan-chain and config-memory loaders). Each user channel gives that logic a parallel capture input and a registered parallel update output with a one-cycle strobe.

## Interface

**Parameters**
- IR_W, 4: instruction register width; must be ≥ 2.
- NUM_DR, 2: number of user data-register channels; must satisfy 1 ≤ NUM_DR ≤ 2^IR_W − 3.
- DR_W, 32: width of each user data register; must be ≥ 1.
- IDCODE_VAL, 32'h149511C3: value captured by IDCODE; bit 0 must be 1.

**Ports**
- tck_pad_i, in, 1: the single clock; all logic uses the rising edge.
- trst_pad_i, in, 1: synchronous, active-high reset.
- tms_pad_i, in, 1: test mode select.
- tdi_pad_i, in, 1: serial data in.
- tdo_pad_o, out, 1: serial data out.
- tdo_padoe_o, out, 1: TDO output enable.
- tap_state_o, out, 4: current TAP state (standard 1149.1 encoding, Test-Logic-Reset = 4'hF).
- ir_o, out, IR_W: active instruction.
- dr_sel_o, out, NUM_DR: one-hot user channel selected by ir_o; all zeros if none.
- dr_capture_i, in, NUM_DR*DR_W: parallel capture data; channel k is bits [k*DR_W +: DR_W].
- dr_update_o, out, NUM_DR*DR_W: registered parallel update data, same slicing as dr_capture_i.
- dr_update_stb_o, out, NUM_DR: one-cycle pulse on channel k when its update register is written.

## Operation

**State machine**
- 16-state 1149.1 TAP FSM with the standard TMS-driven transitions.
- The state register updates on every rising edge of tck_pad_i.

**Instruction decode**
- IDCODE = 1.
- USER_k = 2 + k, for k = 0 … NUM_DR − 1.
- BYPASS = all ones.
- Any other code selects BYPASS.

**Chain lengths**
- BYPASS: 1 bit.
- IDCODE: 32 bits.
- USER_k: DR_W bits.
- IR: IR_W bits.

**Actions** (each occurs on the rising edge while the FSM is in the named state)
- Capture-IR: IR shift register ← {0…0, 2'b01}.
- Capture-DR: the selected chain loads its capture value:
  - BYPASS loads 0.
  - IDCODE loads IDCODE_VAL.
  - USER_k loads its dr_capture_i slice.
- Shift-IR / Shift-DR: the active chain shifts right by one. tdi_pad_i enters the MSB of that chain. This includes the edge that exits to Exit1.
- Update-IR: ir_o ← IR shift register.
- Update-DR with USER_k selected:
  - dr_update_o slice k ← the chain.
  - dr_update_stb_o[k] = 1 for exactly the next cycle.
- Update-DR with BYPASS or IDCODE selected: no side effect.

**Serial output**
- tdo_pad_o is combinationally the LSB of the active chain while in Shift-IR or Shift-DR; otherwise 0.
- tdo_padoe_o = 1 only in Shift-IR or Shift-DR.

**Reset behaviour**
- Test-Logic-Reset, entered either by trst_pad_i or by TMS held high, forces ir_o = IDCODE.
- In Pause-DR/Pause-IR the chains hold their contents.

## Timing

**Reset values** (after the edge on which trst_pad_i = 1)
- tap_state_o = 4'hF.
- ir_o = IDCODE.
- dr_sel_o = 0.
- dr_update_o = 0.
- dr_update_stb_o = 0.
- tdo_pad_o = 0.
- tdo_padoe_o = 0.

**Latencies**
- FSM: one edge per transition.
- Five consecutive edges with TMS = 1 reach Test-Logic-Reset from any state.
- Update: data and strobe are visible one cycle after the edge spent in Update-DR.
- BYPASS: TDI-to-TDO latency is one edge.

**Boundary conditions**
- trst_pad_i asserted mid-shift: no update occurs, the strobe stays 0, and dr_update_o retains its value. It is cleared only by the reset itself, which zeroes it.
- TMS-driven reset does not clear dr_update_o; only trst_pad_i does.
- Shift counts longer than the chain: excess TDI bits push out earlier bits; only the last N bits shifted in are kept.
- Shift counts shorter than the chain: the high bits keep their captured value shifted down.
- Update-IR followed directly by Capture-DR (via Select-DR): the newly loaded instruction governs that capture.
- At most one dr_update_stb_o bit is high in any cycle.

## Test plan

1. **IDCODE after reset.** Pulse trst_pad_i, walk to Shift-DR, shift 32 bits with TDI = 0 → TDO emits 0x149511C3 LSB first; tdo_padoe_o = 1 only during the shift.
2. **IR capture and BYPASS.** Shift IR with 4'hF → TDO returns 4'b0001 and ir_o = 4'hF after Update-IR. Then shift DR with 8'hA5 → TDO reproduces 8'hA5 delayed by one bit, with a leading 0.
3. **User write.** Load IR = 2, shift 32'hDEADBEEF, Update-DR → dr_update_o[31:0] = DEADBEEF and dr_update_stb_o = 2'b01 for exactly one cycle; channel 1 is unchanged.
4. **User capture.** Set dr_capture_i[63:32] = 32'h12345678, load IR = 3, shift 32 bits → TDO emits 0x12345678 LSB first; dr_sel_o = 2'b10.
5. **Unmapped code and reset mid-shift.** With IR = 4'h7 (NUM_DR = 2), the DR chain behaves as 1-bit bypass. Assert trst_pad_i after 10 shift bits of a USER_0 write → no strobe, dr_update_o = 0, ir_o = IDCODE.
6. **TMS reset.** From Shift-DR, drive five TMS = 1 edges → tap_state_o = 4'hF and ir_o = IDCODE; a previously written dr_update_o is retained.
